rotator: RTL and testbench

//  Pipelined 2-D point rotator for the video coordinate path: rotates a signed
//  (Xcoord,Ycoord) point about the origin by Angle (256 steps per full turn).

---
 rtl/rotator.sv | 203 ++++++++++++++++++++
 tb/tb_rotator.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rotator.sv
`default_nettype none
// ============================================================================
// rotator : 3-stage pipelined 2-D point rotator, quarter-wave sin/cos LUT.
// Option macro: ROTATOR_SAT_EN (clamp out-of-range results instead of wrap).
// Revision: 1.0
// ============================================================================
module rotator #(
  parameter int COORD_W = 8,
  parameter int FRAC_W  = 14
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      ENB,
  input  logic signed [COORD_W-1:0] Xcoord,
  input  logic signed [COORD_W-1:0] Ycoord,
  input  logic        [7:0]         Angle,
  output logic signed [COORD_W-1:0] Xout,
  output logic signed [COORD_W-1:0] Yout,
  output logic                      VALID
);

  localparam int LUT_W = FRAC_W + 1;
  localparam int CW    = LUT_W + 1;
  localparam int PW    = COORD_W + CW;
  localparam int SW    = PW + 1;

  localparam logic signed [SW-1:0] C_HALF  = SW'(2 ** (FRAC_W - 1));
  localparam logic signed [SW-1:0] C_R_MAX = SW'(2 ** (COORD_W - 1) - 1);
  localparam logic signed [SW-1:0] C_R_MIN = SW'(-(2 ** (COORD_W - 1)));

  // Quarter-wave table: round(2^14 * sin(2*pi*k/256)), k = 0..64.
  function automatic logic [LUT_W-1:0] lut(input logic [6:0] idx);
    case (idx)
      7'd0:  lut = LUT_W'(0);
      7'd1:  lut = LUT_W'(402);
      7'd2:  lut = LUT_W'(804);
      7'd3:  lut = LUT_W'(1205);
      7'd4:  lut = LUT_W'(1606);
      7'd5:  lut = LUT_W'(2006);
      7'd6:  lut = LUT_W'(2404);
      7'd7:  lut = LUT_W'(2801);
      7'd8:  lut = LUT_W'(3196);
      7'd9:  lut = LUT_W'(3590);
      7'd10: lut = LUT_W'(3981);
      7'd11: lut = LUT_W'(4370);
      7'd12: lut = LUT_W'(4756);
      7'd13: lut = LUT_W'(5139);
      7'd14: lut = LUT_W'(5520);
      7'd15: lut = LUT_W'(5897);
      7'd16: lut = LUT_W'(6270);
      7'd17: lut = LUT_W'(6639);
      7'd18: lut = LUT_W'(7005);
      7'd19: lut = LUT_W'(7366);
      7'd20: lut = LUT_W'(7723);
      7'd21: lut = LUT_W'(8076);
      7'd22: lut = LUT_W'(8423);
      7'd23: lut = LUT_W'(8765);
      7'd24: lut = LUT_W'(9102);
      7'd25: lut = LUT_W'(9434);
      7'd26: lut = LUT_W'(9760);
      7'd27: lut = LUT_W'(10080);
      7'd28: lut = LUT_W'(10394);
      7'd29: lut = LUT_W'(10702);
      7'd30: lut = LUT_W'(11003);
      7'd31: lut = LUT_W'(11297);
      7'd32: lut = LUT_W'(11585);
      7'd33: lut = LUT_W'(11866);
      7'd34: lut = LUT_W'(12140);
      7'd35: lut = LUT_W'(12406);
      7'd36: lut = LUT_W'(12665);
      7'd37: lut = LUT_W'(12916);
      7'd38: lut = LUT_W'(13160);
      7'd39: lut = LUT_W'(13395);
      7'd40: lut = LUT_W'(13623);
      7'd41: lut = LUT_W'(13842);
      7'd42: lut = LUT_W'(14053);
      7'd43: lut = LUT_W'(14256);
      7'd44: lut = LUT_W'(14449);
      7'd45: lut = LUT_W'(14635);
      7'd46: lut = LUT_W'(14811);
      7'd47: lut = LUT_W'(14978);
      7'd48: lut = LUT_W'(15137);
      7'd49: lut = LUT_W'(15286);
      7'd50: lut = LUT_W'(15426);
      7'd51: lut = LUT_W'(15557);
      7'd52: lut = LUT_W'(15679);
      7'd53: lut = LUT_W'(15791);
      7'd54: lut = LUT_W'(15893);
      7'd55: lut = LUT_W'(15986);
      7'd56: lut = LUT_W'(16069);
      7'd57: lut = LUT_W'(16143);
      7'd58: lut = LUT_W'(16207);
      7'd59: lut = LUT_W'(16261);
      7'd60: lut = LUT_W'(16305);
      7'd61: lut = LUT_W'(16340);
      7'd62: lut = LUT_W'(16364);
      7'd63: lut = LUT_W'(16379);
      7'd64: lut = LUT_W'(16384);
      default: lut = LUT_W'(0);
    endcase
  endfunction

  function automatic logic [COORD_W-1:0] limit(input logic signed [SW-1:0] r);
`ifdef ROTATOR_SAT_EN
    if (r > C_R_MAX) begin
      limit = COORD_W'(C_R_MAX);
    end else if (r < C_R_MIN) begin
      limit = COORD_W'(C_R_MIN);
    end else begin
      limit = COORD_W'(r);
    end
`else
    limit = COORD_W'(r);
`endif
  endfunction

  logic                      valid1_q, valid1_d;
  logic signed [COORD_W-1:0] x1_q, x1_d, y1_q, y1_d;
  logic signed [CW-1:0]      c1_q, c1_d, s1_q, s1_d;
  logic                      valid2_q, valid2_d;
  logic signed [PW-1:0]      pxc_q, pxc_d, pys_q, pys_d, pxs_q, pxs_d, pyc_q, pyc_d;
  logic                      valid3_q, valid3_d;
  logic signed [COORD_W-1:0] xout_q, xout_d, yout_q, yout_d;

  logic [1:0]           quad;
  logic [6:0]           k_fwd, k_rev;
  logic signed [CW-1:0] s_fwd, s_rev, c_sel, s_sel;
  logic signed [SW-1:0] sum_x, sum_y, rnd_x, rnd_y;

  always_comb begin
    // Quadrant from Angle[7:6]; mirrored index 64-k gives the cosine.
    quad  = Angle[7:6];
    k_fwd = {1'b0, Angle[5:0]};
    k_rev = 7'd64 - k_fwd;
    s_fwd = signed'({1'b0, lut(k_fwd)});
    s_rev = signed'({1'b0, lut(k_rev)});
    case (quad)
      2'd0: begin s_sel =  s_fwd; c_sel =  s_rev; end
      2'd1: begin s_sel =  s_rev; c_sel = -s_fwd; end
      2'd2: begin s_sel = -s_fwd; c_sel = -s_rev; end
      default: begin s_sel = -s_rev; c_sel =  s_fwd; end
    endcase

    valid1_d = ENB;
    x1_d     = ENB ? Xcoord : x1_q;
    y1_d     = ENB ? Ycoord : y1_q;
    c1_d     = ENB ? c_sel  : c1_q;
    s1_d     = ENB ? s_sel  : s1_q;

    valid2_d = valid1_q;
    pxc_d    = valid1_q ? x1_q * c1_q : pxc_q;
    pys_d    = valid1_q ? y1_q * s1_q : pys_q;
    pxs_d    = valid1_q ? x1_q * s1_q : pxs_q;
    pyc_d    = valid1_q ? y1_q * c1_q : pyc_q;

    sum_x    = {pxc_q[PW-1], pxc_q} - {pys_q[PW-1], pys_q};
    sum_y    = {pxs_q[PW-1], pxs_q} + {pyc_q[PW-1], pyc_q};
    rnd_x    = (sum_x + C_HALF) >>> FRAC_W;
    rnd_y    = (sum_y + C_HALF) >>> FRAC_W;

    valid3_d = valid2_q;
    xout_d   = valid2_q ? limit(rnd_x) : xout_q;
    yout_d   = valid2_q ? limit(rnd_y) : yout_q;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      valid1_q <= 1'b0;
      x1_q     <= '0;
      y1_q     <= '0;
      c1_q     <= '0;
      s1_q     <= '0;
      valid2_q <= 1'b0;
      pxc_q    <= '0;
      pys_q    <= '0;
      pxs_q    <= '0;
      pyc_q    <= '0;
      valid3_q <= 1'b0;
      xout_q   <= '0;
      yout_q   <= '0;
    end else begin
      valid1_q <= valid1_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      c1_q     <= c1_d;
      s1_q     <= s1_d;
      valid2_q <= valid2_d;
      pxc_q    <= pxc_d;
      pys_q    <= pys_d;
      pxs_q    <= pxs_d;
      pyc_q    <= pyc_d;
      valid3_q <= valid3_d;
      xout_q   <= xout_d;
      yout_q   <= yout_d;
    end
  end

  assign Xout  = xout_q;
  assign Yout  = yout_q;
  assign VALID = valid3_q;

endmodule
`default_nettype wire

// File: tb/tb_rotator.sv
`default_nettype none
// ============================================================================
// tb_rotator : scoreboard bench for rotator with directed, hand-computed vectors.
// Revision: 1.0
// ============================================================================
module tb_rotator;

  logic              ACLK    = 1'b0;
  logic              ARESETN = 1'b0;
  logic              ENB     = 1'b0;
  logic signed [7:0] Xcoord  = '0;
  logic signed [7:0] Ycoord  = '0;
  logic        [7:0] Angle   = '0;
  logic signed [7:0] Xout;
  logic signed [7:0] Yout;
  logic              VALID;

`ifdef ROTATOR_SAT_EN
  localparam logic [7:0] C_Y_DIAG = 8'h7F;
  localparam logic [7:0] C_X_NEG  = 8'h7F;
`else
  localparam logic [7:0] C_Y_DIAG = 8'hB4;
  localparam logic [7:0] C_X_NEG  = 8'h80;
`endif

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       cur;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] last_x = '0;
  logic [7:0] last_y = '0;

  rotator #(.COORD_W(8), .FRAC_W(14)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .ENB     (ENB),
    .Xcoord  (Xcoord),
    .Ycoord  (Ycoord),
    .Angle   (Angle),
    .Xout    (Xout),
    .Yout    (Yout),
    .VALID   (VALID)
  );

  always #5 ACLK = ~ACLK;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Apply one input cycle; expected result queued only for accepted samples.
  task automatic drive(input logic en, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] a, input logic [7:0] ex, input logic [7:0] ey,
                       input bit push);
    ENB    = en;
    Xcoord = x;
    Ycoord = y;
    Angle  = a;
    if (en && push) sb_q.push_back('{x: ex, y: ey});
    @(posedge ACLK);
    #1;
  endtask

  always @(negedge ACLK) begin
    if (ARESETN !== 1'b1) begin
      last_x = '0;
      last_y = '0;
    end else if (VALID === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got VALID=1 with Xout=0x%02h Yout=0x%02h, expected no result at %0t",
                 Xout, Yout, $time);
      end else begin
        cur = sb_q.pop_front();
        check8("xout", Xout, cur.x);
        check8("yout", Yout, cur.y);
      end
      last_x = Xout;
      last_y = Yout;
    end else begin
      check8("hold_x", Xout, last_x);
      check8("hold_y", Yout, last_y);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    ENB    = 1'b1;
    Xcoord = 8'h40;
    Ycoord = 8'h00;
    Angle  = 8'h00;
    repeat (3) @(posedge ACLK);
    #1;
    check8("rst_xout", Xout, 8'h00);
    check8("rst_yout", Yout, 8'h00);
    check1("rst_valid", VALID, 1'b0);

    ARESETN = 1'b1;
    drive(1'b1, 8'h40, 8'h00, 8'h00, 8'h40, 8'h00, 1'b1);
    check1("valid_edge1", VALID, 1'b0);
    drive(1'b1, 8'h40, 8'h00, 8'h40, 8'h00, 8'h40, 1'b1);
    check1("valid_edge2", VALID, 1'b0);
    drive(1'b1, 8'h40, 8'h00, 8'h80, 8'hC0, 8'h00, 1'b1);
    check1("valid_edge3", VALID, 1'b1);
    drive(1'b1, 8'h40, 8'h00, 8'hC0, 8'h00, 8'hC0, 1'b1);

    // Back-to-back samples with a different angle each cycle.
    drive(1'b1, 8'h40, 8'h00, 8'hC9, 8'h0E, 8'hC2,   1'b1);
    drive(1'b1, 8'h40, 8'h00, 8'h09, 8'h3E, 8'h0E,   1'b1);
    drive(1'b1, 8'h7F, 8'h7F, 8'h20, 8'h00, C_Y_DIAG, 1'b1);
    drive(1'b1, 8'h80, 8'h00, 8'h80, C_X_NEG, 8'h00,  1'b1);
    drive(1'b1, 8'h20, 8'h10, 8'h40, 8'hF0, 8'h20,   1'b1);
    drive(1'b1, 8'h05, 8'hFD, 8'h00, 8'h05, 8'hFD,   1'b1);

    // ENB pattern 1,0,1,1 followed by one more sample.
    drive(1'b1, 8'h10, 8'h20, 8'h40, 8'hE0, 8'h10, 1'b1);
    drive(1'b0, 8'h55, 8'h55, 8'h55, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 8'h30, 8'h05, 8'h80, 8'hD0, 8'hFB, 1'b1);
    drive(1'b1, 8'h7F, 8'h00, 8'hC0, 8'h00, 8'h81, 1'b1);
    drive(1'b1, 8'h11, 8'h22, 8'h00, 8'h11, 8'h22, 1'b1);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
      drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results still pending, expected 0", sb_q.size());
      sb_q.delete();
    end
    repeat (2) drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

    // Reset with two samples in flight: neither may produce a result.
    drive(1'b1, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 8'h20, 8'h20, 8'h40, 8'h00, 8'h00, 1'b0);
    ENB     = 1'b0;
    ARESETN = 1'b0;
    #1;
    check8("midrst_xout", Xout, 8'h00);
    check8("midrst_yout", Yout, 8'h00);
    check1("midrst_valid", VALID, 1'b0);
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    repeat (6) drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    check1("post_rst_valid", VALID, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
